// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the scheduling queue.
// Holds the step-kind encodings, iop/init-mask bit positions, the step FSM
// state type and the helper that walks an iop's step list in order.
package core_pkg;

  localparam logic [1:0] STEP_AGU = 2'd0;
  localparam logic [1:0] STEP_LD  = 2'd1;
  localparam logic [1:0] STEP_ALU = 2'd2;
  localparam logic [1:0] STEP_ST  = 2'd3;

  localparam int IOP_ST_MEM = 22;
  localparam int IOP_IS_RMW = 4;

  localparam int INIT_AGU   = 0;
  localparam int INIT_NO_LD = 1;
  localparam int INIT_ALU   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AGU,
    ST_LD,
    ST_ALU,
    ST_ST
  } sched_state_e;

  // Returns the first step strictly after 'cur' that this iop needs, walking
  // AGU, LOAD, ALU, STORE in order. From ST_IDLE it yields the first step of
  // the iop; ST_IDLE as a result means no further step is required.
  function automatic sched_state_e next_step(input sched_state_e cur,
                                             input logic [2:0]   init,
                                             input logic         st_mem);
    logic         from_idle;
    logic         from_agu;
    logic         from_ld;
    logic         from_alu;
    sched_state_e nxt;
    from_idle = (cur == ST_IDLE);
    from_agu  = from_idle || (cur == ST_AGU);
    from_ld   = from_agu  || (cur == ST_LD);
    from_alu  = from_ld   || (cur == ST_ALU);
    nxt = ST_IDLE;
    if (from_idle && init[INIT_AGU]) begin
      nxt = ST_AGU;
    end else if (from_agu && !init[INIT_NO_LD]) begin
      nxt = ST_LD;
    end else if (from_ld && init[INIT_ALU]) begin
      nxt = ST_ALU;
    end else if (from_alu && st_mem) begin
      nxt = ST_ST;
    end
    return nxt;
  endfunction

  // Maps a presenting state onto the externally visible step kind.
  function automatic logic [1:0] state_kind(input sched_state_e s);
    logic [1:0] kind;
    case (s)
      ST_LD:   kind = STEP_LD;
      ST_ALU:  kind = STEP_ALU;
      ST_ST:   kind = STEP_ST;
      default: kind = STEP_AGU;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// sched_fifo: in-order circular buffer of {iop, init} entries for the
// scheduling queue. Exposes the head and the entry behind it so the owner
// can move straight onto the next iop in the same cycle it pops the head.
module sched_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IOP_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [IOP_W-1:0]         i_iop,
  input  logic [2:0]               i_init,
  output logic [IOP_W-1:0]         o_head_iop,
  output logic [2:0]               o_head_init,
  output logic [IOP_W-1:0]         o_next_iop,
  output logic [2:0]               o_next_init,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [IOP_W-1:0] r_iop  [DEPTH];
  logic [2:0]       r_init [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_rd_next;

  assign w_rd_next   = r_rd_ptr + PTR_ONE;
  assign o_head_iop  = r_iop[r_rd_ptr];
  assign o_head_init = r_init[r_rd_ptr];
  assign o_next_iop  = r_iop[w_rd_next];
  assign o_next_init = r_init[w_rd_next];
  assign o_count     = r_count;

  // Pointers and occupancy; flush empties the queue regardless of push/pop.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, cleared on reset so the idle head reads as zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_iop[i]  <= '0;
        r_init[i] <= '0;
      end
    end else if (i_push && !i_flush) begin
      r_iop[r_wr_ptr]  <= i_iop;
      r_init[r_wr_ptr] <= i_init;
    end
  end

endmodule

// File: rtl/sched_queue.sv
// sched_queue: buffers iops from the decoder and walks the head iop through
// its AGU / LOAD / ALU / STORE steps one at a time.
// Optional macro SCHED_BYPASS_EN: a push into an empty idle queue is
// presented in the same cycle straight from the decoder inputs.
module sched_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IOP_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  output logic                     o_id_req,
  input  logic                     i_id_feed,
  input  logic [IOP_W-1:0]         i_id_iop,
  input  logic [2:0]               i_id_iop_init,
  output logic                     o_step_valid,
  output logic [1:0]               o_step_kind,
  output logic [IOP_W-1:0]         o_step_iop,
  input  logic                     i_step_done,
  output logic [$clog2(DEPTH):0]   o_q_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [IOP_W-1:0] w_head_iop;
  logic [IOP_W-1:0] w_next_iop;
  logic [IOP_W-1:0] w_cur_iop;
  logic [2:0]       w_head_init;
  logic [2:0]       w_next_init;
  logic [2:0]       w_cur_init;
  logic [CW-1:0]    w_count;
  logic             w_id_req;
  logic             w_push;
  logic             w_pop;
  logic             w_head_valid;
  logic             w_bypass;

  sched_state_e r_state;
  sched_state_e w_state_next;
  sched_state_e w_cur_state;
  sched_state_e w_feed_first;
  sched_state_e w_head_first;
  sched_state_e w_after_first;
  sched_state_e w_step_after;

  assign w_id_req     = (w_count < CW'(DEPTH)) && !i_flush;
  assign w_push       = i_id_feed && w_id_req;
  assign w_head_valid = (w_count != '0);

`ifdef SCHED_BYPASS_EN
  assign w_bypass = (r_state == ST_IDLE) && !w_head_valid && w_push;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_feed_first = next_step(ST_IDLE, i_id_iop_init, i_id_iop[IOP_ST_MEM]);
  assign w_head_first = next_step(ST_IDLE, w_head_init, w_head_iop[IOP_ST_MEM]);
  assign w_step_after = next_step(w_cur_state, w_cur_init, w_cur_iop[IOP_ST_MEM]);

  sched_fifo #(
    .DEPTH (DEPTH),
    .IOP_W (IOP_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_flush     (i_flush),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_iop       (i_id_iop),
    .i_init      (i_id_iop_init),
    .o_head_iop  (w_head_iop),
    .o_head_init (w_head_init),
    .o_next_iop  (w_next_iop),
    .o_next_init (w_next_init),
    .o_count     (w_count)
  );

  // Selects what is being presented: the registered state on the stored head,
  // or the decoder's iop directly while it bypasses an empty queue.
  always_comb begin
    w_cur_state = r_state;
    w_cur_iop   = w_head_iop;
    w_cur_init  = w_head_init;
    if (w_bypass) begin
      w_cur_state = w_feed_first;
      w_cur_iop   = i_id_iop;
      w_cur_init  = i_id_iop_init;
    end
  end

  // First step of whichever iop becomes head once the current head is popped;
  // that may be the iop being pushed this very cycle.
  always_comb begin
    w_after_first = ST_IDLE;
    if (w_count > CW'(1)) begin
      w_after_first = next_step(ST_IDLE, w_next_init, w_next_iop[IOP_ST_MEM]);
    end else if ((w_count == CW'(1)) && w_push) begin
      w_after_first = w_feed_first;
    end
  end

  // Next-state and pop decision for the step sequencer.
  always_comb begin
    w_state_next = w_cur_state;
    w_pop        = 1'b0;
    if (i_flush) begin
      w_state_next = ST_IDLE;
    end else if (w_cur_state == ST_IDLE) begin
      if (w_head_valid) begin
        if (w_head_first == ST_IDLE) begin
          w_pop        = 1'b1;
          w_state_next = w_after_first;
        end else begin
          w_state_next = w_head_first;
        end
      end else if (w_push) begin
        w_state_next = w_feed_first;
      end
    end else if (i_step_done) begin
      if (w_step_after != ST_IDLE) begin
        w_state_next = w_step_after;
      end else begin
        w_pop        = 1'b1;
        w_state_next = w_after_first;
      end
    end
  end

  // Step FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign o_id_req     = w_id_req;
  assign o_step_valid = (w_cur_state != ST_IDLE);
  assign o_step_kind  = state_kind(w_cur_state);
  assign o_step_iop   = w_cur_iop;
  assign o_q_count    = w_count;

endmodule
